// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receiver (start, LSB-first data, optional parity, one stop bit)
// with sticky status flags that the host acknowledges through rx_clear.
module uart_rx_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int BAUD_DIV   = 434,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   input  logic                  rx_clear,
   output logic [DATA_WIDTH-1:0] Received_DATA,
   output logic                  rx_interrupt,
   output logic                  parity_error,
   output logic                  framing_error,
   output logic                  overrun_error
);

   localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(BAUD_DIV - 1);
   // Preload so the start-bit sample lands BAUD_DIV/2 cycles after the falling edge.
   localparam logic [CNT_W-1:0] CNT_HALF    = CNT_W'(BAUD_DIV - BAUD_DIV / 2);
   localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(DATA_WIDTH - 1);
   localparam logic             PAR_ODD_BIT = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      DONE
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic                    rx_meta;
   logic                    rx_s;
   logic                    rx_s_d;
   logic                    rx_fall;
   logic [CNT_W-1:0]        cnt;
   logic                    tick;
   logic [IDX_W-1:0]        bit_idx;
   logic [DATA_WIDTH-1:0]   shreg;
   logic                    par_err_r;
   logic                    frm_err_r;
   logic                    shift_en;
   logic                    par_load;
   logic                    stop_load;
   logic                    commit;

   // NOTE: sequential state is always assigned with <=, so every flop samples
   // the pre-edge value of its neighbours regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_s_d  <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_s_d  <= rx_s;
      end
   end

   assign rx_fall = rx_s_d & ~rx_s;
   assign tick    = (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: state_next gets a default before the case, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (rx_fall) begin
               state_next = START;
            end
         end
         START: begin
            if (tick) begin
               state_next = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (tick && (bit_idx == IDX_LAST)) begin
               state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (tick) begin
               state_next = STOP;
            end
         end
         STOP: begin
            if (tick) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      shift_en  = 1'b0;
      par_load  = 1'b0;
      stop_load = 1'b0;
      commit    = 1'b0;
      unique case (state)
         DATA:    shift_en  = tick;
         PARITY:  par_load  = tick;
         STOP:    stop_load = tick;
         DONE:    commit    = 1'b1;
         default: ;
      endcase
   end

   // Baud counter restarts on every state change; it stays parked at 0 in IDLE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (state_next != state) begin
         cnt <= (state_next == START) ? CNT_HALF : '0;
      end else if ((state == IDLE) || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bit_idx <= '0;
      end else if (state != DATA) begin
         bit_idx <= '0;
      end else if (shift_en) begin
         bit_idx <= bit_idx + IDX_W'(1);
      end
   end

   // NOTE: the shift register is pure datapath and is fully refilled before
   // every commit, so it carries no reset.
   always_ff @(posedge clk) begin
      if (shift_en) begin
         shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         par_err_r <= 1'b0;
         frm_err_r <= 1'b0;
      end else begin
         if (par_load) begin
            par_err_r <= ((^shreg) ^ rx_s) != PAR_ODD_BIT;
         end
         if (stop_load) begin
            frm_err_r <= ~rx_s;
         end
      end
   end

   // A commit wins over rx_clear; the clear only drops the previously held flags.
   always_ff @(posedge clk) begin
      if (!rst) begin
         Received_DATA <= '0;
         rx_interrupt  <= 1'b0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
         overrun_error <= 1'b0;
      end else if (commit) begin
         Received_DATA <= shreg;
         rx_interrupt  <= 1'b1;
         parity_error  <= (parity_error  & ~rx_clear) | par_err_r;
         framing_error <= (framing_error & ~rx_clear) | frm_err_r;
         overrun_error <= (overrun_error & ~rx_clear) | rx_interrupt;
      end else if (rx_clear) begin
         rx_interrupt  <= 1'b0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
         overrun_error <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and randomized frames against a frame-level model of
// the receiver's data word and sticky flags.
module tb_uart_rx_ctrl;

   localparam int BAUD    = 16;
   localparam int DW      = 8;
   localparam int PAR_EN  = 1;
   localparam int PAR_ODD = 0;
   // Negedges from driving the stop bit to just after its sample edge:
   // two synchronizer flops, edge detect, then half a bit.
   localparam int STOP_WAIT = 2 + BAUD / 2 + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx;
   logic          rx_clear;
   logic [DW-1:0] received_data;
   logic          rx_interrupt;
   logic          parity_error;
   logic          framing_error;
   logic          overrun_error;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] m_data;
   logic          m_irq;
   logic          m_perr;
   logic          m_ferr;
   logic          m_oerr;

   uart_rx_ctrl #(
      .DATA_WIDTH (DW),
      .BAUD_DIV   (BAUD),
      .PARITY_EN  (PAR_EN),
      .PARITY_ODD (PAR_ODD)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx            (rx),
      .rx_clear      (rx_clear),
      .Received_DATA (received_data),
      .rx_interrupt  (rx_interrupt),
      .parity_error  (parity_error),
      .framing_error (framing_error),
      .overrun_error (overrun_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_data"}, 32'(received_data), 32'(m_data));
      check({tag, "_irq"},  32'(rx_interrupt),  32'(m_irq));
      check({tag, "_perr"}, 32'(parity_error),  32'(m_perr));
      check({tag, "_ferr"}, 32'(framing_error), 32'(m_ferr));
      check({tag, "_oerr"}, 32'(overrun_error), 32'(m_oerr));
   endtask

   task automatic model_reset();
      m_data = '0;
      m_irq  = 1'b0;
      m_perr = 1'b0;
      m_ferr = 1'b0;
      m_oerr = 1'b0;
   endtask

   task automatic pulse_clear(input string tag);
      rx_clear = 1'b1;
      @(negedge clk);
      rx_clear = 1'b0;
      m_irq  = 1'b0;
      m_perr = 1'b0;
      m_ferr = 1'b0;
      m_oerr = 1'b0;
      check_all(tag);
   endtask

   // Drives one whole frame, one bit per BAUD cycles, and checks the
   // interrupt edge against the stop-bit sample point.
   task automatic send_frame(input string tag, input logic [DW-1:0] d, input bit bad_par,
                             input bit stop_bit, input bit clr_at_done, input int gap);
      logic pbit;
      bit   perr_f;
      pbit = (^d) ^ 1'(PAR_ODD) ^ bad_par;
      rx = 1'b0;
      repeat (BAUD) @(negedge clk);
      for (int i = 0; i < DW; i++) begin
         rx = d[i];
         repeat (BAUD) @(negedge clk);
      end
      if (PAR_EN != 0) begin
         rx = pbit;
         repeat (BAUD) @(negedge clk);
      end
      rx = stop_bit;
      repeat (STOP_WAIT) @(negedge clk);
      check({tag, "_irq_pre"}, 32'(rx_interrupt), 32'(m_irq));
      if (clr_at_done) rx_clear = 1'b1;
      @(negedge clk);
      rx_clear = 1'b0;
      perr_f = (PAR_EN != 0) ? (((^d) ^ pbit) != 1'(PAR_ODD)) : 1'b0;
      if (clr_at_done) begin
         m_perr = 1'b0;
         m_ferr = 1'b0;
         m_oerr = m_irq;
      end else begin
         m_oerr = m_oerr | m_irq;
      end
      m_perr = m_perr | perr_f;
      m_ferr = m_ferr | !stop_bit;
      m_irq  = 1'b1;
      m_data = d;
      check_all(tag);
      repeat (BAUD - STOP_WAIT - 1) @(negedge clk);
      rx = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   initial begin
      rst      = 1'b0;
      rx       = 1'b1;
      rx_clear = 1'b0;
      model_reset();

      // Reset and quiet idle line
      repeat (3) @(negedge clk);
      check_all("reset");
      rst = 1'b1;
      repeat (40) @(negedge clk);
      check_all("idle");

      // Good frame, then acknowledge
      send_frame("a5", 8'hA5, 1'b0, 1'b1, 1'b0, 6);
      pulse_clear("a5_clr");

      // Wrong parity bit
      send_frame("3c_par", 8'h3C, 1'b1, 1'b1, 1'b0, 6);
      pulse_clear("3c_clr");

      // Framing error, then overrun with sticky framing flag
      send_frame("81_frm", 8'h81, 1'b0, 1'b0, 1'b0, 6);
      send_frame("55_ovr", 8'h55, 1'b0, 1'b1, 1'b0, 6);
      pulse_clear("55_clr");

      // Short glitch is rejected as a false start
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check_all("glitch");
      send_frame("0f", 8'h0F, 1'b0, 1'b1, 1'b0, 6);

      // Reset in the middle of the data bits
      rx = 1'b0;
      repeat (BAUD) @(negedge clk);
      rx = 1'b1;
      repeat (3 * BAUD) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      model_reset();
      check_all("mid_rst");
      rst = 1'b1;
      repeat (12 * BAUD) @(negedge clk);
      check_all("post_rst");

      // Clear on the commit cycle: set wins, overrun uses the pre-clear interrupt
      send_frame("12_clrdone", 8'h12, 1'b0, 1'b1, 1'b1, 6);
      send_frame("c3_frm", 8'hC3, 1'b0, 1'b0, 1'b0, 6);
      send_frame("6a_clrdone", 8'h6A, 1'b0, 1'b1, 1'b1, 6);

      // Randomized frames
      for (int n = 0; n < 12; n++) begin
         if ($urandom_range(0, 2) == 0) pulse_clear("rnd_clr");
         send_frame("rnd", 8'($urandom), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0),
                    int'($urandom_range(4, 12)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
